// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Receive end of a stochastic-computing bitstream link. Counts the 1s in
//   consecutive windows of 2^WIDTH accepted bits and hands each window's count
//   to a binary consumer over a valid/ready handshake. A completed result can
//   wait in the accumulator (STALL) while the output register is still occupied,
//   so no result is lost under backpressure.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   en_i           enable; low pauses bit intake (output side keeps running)
//   clr_i          synchronous clear of the partial window (ignored in STALL)
//   bs_in_i        stochastic bit
//   bs_valid_i     bs_in_i is valid
//   bs_ready_o     decoder accepts bs_in_i this cycle (combinational)
//   bin_out_o      count of 1s in the completed window, 0..2^WIDTH
//   bin_valid_o    bin_out_o holds an unconsumed result
//   bin_ready_i    consumer accepts bin_out_o
//   window_done_o  one-cycle pulse after the last bit of a window is accepted
//
// state | meaning
// ACCUM | accepting bits into acc_q / bit_cnt_q
// STALL | acc_q holds a finished window waiting for the output register

module sc_stream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             bs_in_i,
  input  logic             bs_valid_i,
  output logic             bs_ready_o,
  output logic [WIDTH:0]   bin_out_o,
  output logic             bin_valid_o,
  input  logic             bin_ready_i,
  output logic             window_done_o
);

  typedef enum logic {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH:0]   bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             window_done_q, window_done_d;

  logic             accept;
  logic             out_take;
  logic [WIDTH:0]   fin_sum;

  // Reads 0 during reset even though it is combinational.
  assign bs_ready_o = rst_ni & en_i & ~clr_i & (state_q == ACCUM);
  assign accept     = bs_valid_i & bs_ready_o;
  assign out_take   = bin_valid_q & bin_ready_i;
  assign fin_sum    = acc_q + {{WIDTH{1'b0}}, bs_in_i};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    bin_out_d     = bin_out_q;
    bin_valid_d   = bin_valid_q;
    window_done_d = 1'b0;

    if (out_take) begin
      bin_valid_d = 1'b0;
    end

    unique case (state_q)
      ACCUM: begin
        if (clr_i) begin
          acc_d     = '0;
          bit_cnt_d = '0;
        end else if (accept) begin
          bit_cnt_d = bit_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
          if (bit_cnt_q == {WIDTH{1'b1}}) begin
            window_done_d = 1'b1;
            // Output register is free if empty or being drained this cycle.
            if (!bin_valid_q || bin_ready_i) begin
              bin_out_d   = fin_sum;
              bin_valid_d = 1'b1;
              acc_d       = '0;
            end else begin
              acc_d   = fin_sum;
              state_d = STALL;
            end
          end else begin
            acc_d = fin_sum;
          end
        end
      end
      STALL: begin
        // bin_valid_q is always 1 here; hand the parked result over.
        if (out_take) begin
          bin_out_d   = acc_q;
          bin_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      bin_out_q     <= '0;
      bin_valid_q   <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      bin_out_q     <= bin_out_d;
      bin_valid_q   <= bin_valid_d;
      window_done_q <= window_done_d;
    end
  end

  assign bin_out_o     = bin_out_q;
  assign bin_valid_o   = bin_valid_q;
  assign window_done_o = window_done_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder with WIDTH=4 (16-bit windows). A queue-based
// model of pending results runs alongside the DUT and is compared every cycle;
// directed scenarios add literal expectations on consumed results.
module tb_sc_stream_decoder;
  localparam int WIDTH = 4;
  localparam int N     = 1 << WIDTH;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             en_i = 1'b0;
  logic             clr_i = 1'b0;
  logic             bs_in_i = 1'b0;
  logic             bs_valid_i = 1'b0;
  logic             bs_ready_o;
  logic [WIDTH:0]   bin_out_o;
  logic             bin_valid_o;
  logic             bin_ready_i = 1'b0;
  logic             window_done_o;

  sc_stream_decoder #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .bs_in_i      (bs_in_i),
    .bs_valid_i   (bs_valid_i),
    .bs_ready_o   (bs_ready_o),
    .bin_out_o    (bin_out_o),
    .bin_valid_o  (bin_valid_o),
    .bin_ready_i  (bin_ready_i),
    .window_done_o(window_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: completed results waiting for the consumer (output reg + parked one),
  // plus the partial window count.
  int pend[$];
  int last_out  = 0;
  int part_n    = 0;
  int part_ones = 0;
  bit m_wd      = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend.delete();
      last_out  = 0;
      part_n    = 0;
      part_ones = 0;
      m_wd      = 1'b0;
    end else begin
      bit full, rdy, accp;
      full = (pend.size() == 2);
      rdy  = en_i && !clr_i && !full;
      accp = bs_valid_i && rdy;
      if (pend.size() > 0 && bin_ready_i) last_out = pend.pop_front();
      m_wd = 1'b0;
      if (clr_i && !full) begin
        part_n    = 0;
        part_ones = 0;
      end else if (accp) begin
        part_ones += int'(bs_in_i);
        part_n++;
        if (part_n == N) begin
          pend.push_back(part_ones);
          part_n    = 0;
          part_ones = 0;
          m_wd      = 1'b1;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk_i) begin
    if (chk_en) begin
      bit e_ready;
      e_ready = rst_ni && en_i && !clr_i && (pend.size() < 2);
      chk("model_bs_ready", bs_ready_o, e_ready);
      chk("model_bin_valid", bin_valid_o, pend.size() > 0);
      chk("model_bin_out", bin_out_o, (pend.size() > 0) ? pend[0] : last_out);
      chk("model_window_done", window_done_o, m_wd);
    end
  end

  // Results actually consumed over the output handshake.
  int got[$];
  always @(negedge clk_i) begin
    if (rst_ni && bin_valid_o && bin_ready_i) got.push_back(int'(bin_out_o));
  end

  function automatic int last_got();
    return (got.size() > 0) ? got[got.size()-1] : -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input bit b);
    bit r;
    int n;
    bs_valid_i = 1'b1;
    bs_in_i    = b;
    n = 0;
    forever begin
      @(negedge clk_i);
      r = bs_ready_o;
      tick();
      if (r) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_bit_timeout got not-ready expected ready at %0t", $time);
        break;
      end
    end
  endtask

  int  t0;
  int  acc_cnt;
  int  ones;
  bit  pat[16];

  initial begin
    // 1: reset state and en=0
    tick();
    @(negedge clk_i);
    chk("rst_bin_valid", bin_valid_o, 0);
    chk("rst_bin_out", bin_out_o, 0);
    chk("rst_bs_ready", bs_ready_o, 0);
    chk("rst_window_done", window_done_o, 0);
    tick();
    rst_ni     = 1'b1;
    bs_valid_i = 1'b1;
    bs_in_i    = 1'b1;
    chk_en     = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("en0_bs_ready", bs_ready_o, 0);
      tick();
    end

    // 2: 16 ones, full-scale result
    en_i        = 1'b1;
    bin_ready_i = 1'b1;
    for (int i = 0; i < N; i++) send_bit(1'b1);
    bs_valid_i = 1'b0;
    @(negedge clk_i);
    chk("full_bin_valid", bin_valid_o, 1);
    chk("full_bin_out", bin_out_o, 16);
    chk("full_window_done", window_done_o, 1);
    tick();
    @(negedge clk_i);
    chk("full_wd_pulse_end", window_done_o, 0);
    chk("full_consumed", last_got(), 16);

    // 1b: async reset mid-stream
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_bs_ready", bs_ready_o, 0);
    chk("midrst_bin_valid", bin_valid_o, 0);
    chk("midrst_bin_out", bin_out_o, 0);
    tick();
    rst_ni = 1'b1;

    // 3: back-to-back windows, 1010... then zeros
    t0 = $time;
    for (int i = 0; i < N; i++) send_bit((i % 2) == 0);
    for (int i = 0; i < N; i++) send_bit(1'b0);
    bs_valid_i = 1'b0;
    chk("b2b_cycles", ($time - t0) / 10, 32);
    tick();
    tick();
    chk("b2b_count", got.size(), 3);
    chk("b2b_win1", got[1], 8);
    chk("b2b_win2", got[2], 0);

    // 4: backpressure into STALL and drain
    bin_ready_i = 1'b0;
    for (int i = 0; i < N; i++) send_bit(i < 5);
    for (int i = 0; i < N; i++) send_bit(i < 11);
    bs_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      chk("stall_bs_ready", bs_ready_o, 0);
      chk("stall_bin_out", bin_out_o, 5);
      chk("stall_bin_valid", bin_valid_o, 1);
      tick();
    end
    bin_ready_i = 1'b1;
    @(negedge clk_i);
    chk("drain_first", bin_out_o, 5);
    tick();
    @(negedge clk_i);
    chk("drain_second", bin_out_o, 11);
    chk("drain_valid", bin_valid_o, 1);
    chk("drain_ready_back", bs_ready_o, 1);
    tick();
    @(negedge clk_i);
    chk("drain_empty", bin_valid_o, 0);
    chk("drain_got", last_got(), 11);

    // 5: clr discards partial windows
    pat = '{1,1,0,1,0,0,1,0,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 7; i++) send_bit(pat[i]);
    clr_i = 1'b1;
    @(negedge clk_i);
    chk("clr_bs_ready", bs_ready_o, 0);
    tick();
    clr_i = 1'b0;
    for (int i = 0; i < N; i++) send_bit(i == 2 || i == 9 || i == 15);
    bs_valid_i = 1'b0;
    tick();
    tick();
    chk("clr_result", last_got(), 3);
    for (int i = 0; i < N - 1; i++) send_bit(1'b1);
    bs_in_i = 1'b1;
    clr_i   = 1'b1;
    tick();
    clr_i      = 1'b0;
    bs_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("clr_last_no_valid", bin_valid_o, 0);
      chk("clr_last_no_done", window_done_o, 0);
      tick();
    end
    for (int i = 0; i < N; i++) send_bit(1'b0);
    bs_valid_i = 1'b0;
    tick();
    tick();
    chk("clr_after_zero", last_got(), 0);

    // 6: random bs_valid with en dropped mid-window
    acc_cnt = 0;
    ones    = 0;
    for (int cyc = 0; cyc < 300 && acc_cnt < N; cyc++) begin
      bs_valid_i = 1'($urandom_range(0, 1));
      bs_in_i    = 1'($urandom_range(0, 1));
      en_i       = !(cyc >= 5 && cyc < 15);
      @(negedge clk_i);
      if (bs_valid_i && bs_ready_o) begin
        acc_cnt++;
        ones += int'(bs_in_i);
      end
      tick();
    end
    chk("rand_accepted", acc_cnt, N);
    en_i       = 1'b1;
    bs_valid_i = 1'b0;
    tick();
    tick();
    chk("rand_count", last_got(), ones);

    // 6b: async reset while in STALL
    bin_ready_i = 1'b0;
    for (int i = 0; i < 2 * N; i++) send_bit(1'b1);
    bs_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_stall", bs_ready_o, 0);
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("stallrst_bin_valid", bin_valid_o, 0);
    chk("stallrst_bin_out", bin_out_o, 0);
    chk("stallrst_bs_ready", bs_ready_o, 0);
    tick();
    rst_ni      = 1'b1;
    bin_ready_i = 1'b1;
    for (int i = 0; i < N; i++) send_bit(i == 4 || i == 12);
    bs_valid_i = 1'b0;
    tick();
    tick();
    chk("stallrst_acc_cleared", last_got(), 2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
